// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states, memory timing.
package lsu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned MEM_RD_LAT = 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RD_WAIT  = 2'b01,
        RMW_WAIT = 2'b10,
        ERR      = 2'b11
    } state_t;

    // Half needs addr[0]==0, word needs addr[1:0]==0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte/half lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rd_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data_c,
    output logic [DATA_W-1:0] merge_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = rd_word[{addr_lo, 3'b000} +: 8];
        half_sel    = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        load_data_c = rd_word;
        case (size)
            SZ_BYTE: load_data_c = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_c = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data_c = rd_word;
        endcase
    end

    // Only the addressed lanes take store data; the rest keep the word just read.
    always_comb begin
        merge_data_c = rd_word;
        case (size)
            SZ_BYTE: merge_data_c[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) merge_data_c[31:16] = wdata[15:0];
                else            merge_data_c[15:0]  = wdata[15:0];
            end
            default: merge_data_c = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns byte/half/word accesses into full-word SPRAM reads/writes.
// LSU_MISALIGN_TRAP_EN: misaligned half/word accesses error instead of being aligned down.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_data_valid,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
);

    if (RD_TIMEOUT < 3 || RD_TIMEOUT > 255 || RD_TIMEOUT <= MEM_RD_LAT) begin : g_bad_timeout
        $error("lsu_ctrl: RD_TIMEOUT out of range 3..255");
    end

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        cap_size;
    logic              cap_unsigned;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              accept_c;
    logic              acc_err_c;
    logic [ADDR_W-1:0] acc_addr_c;
    logic              timeout_c;
    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] merge_data_c;

    assign req_ready = (state_q == IDLE);
    assign accept_c  = req_valid && req_ready;
    assign timeout_c = ((9'(cnt_q) + 9'd1) >= 9'(RD_TIMEOUT));

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_err_c = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]);
`else
    assign acc_err_c = (req_size == SZ_RSVD);
`endif

    // Misaligned addresses only survive to here when trapping is off; drop the low bits.
    always_comb begin
        acc_addr_c = req_addr;
        if (req_size == SZ_HALF) acc_addr_c[0]   = 1'b0;
        if (req_size == SZ_WORD) acc_addr_c[1:0] = 2'b00;
    end

    lsu_lane_unit u_lane (
        .size         (cap_size),
        .is_unsigned  (cap_unsigned),
        .addr_lo      (cap_addr[1:0]),
        .rd_word      (mem_rd_data),
        .wdata        (cap_wdata),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cap_size     <= SZ_BYTE;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            mem_rd_req   <= 1'b0;
            mem_rd_addr  <= '0;
            mem_wr_req   <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_addr     <= acc_addr_c;
                        cap_wdata    <= req_wdata;
                        cnt_q        <= '0;
                        if (acc_err_c) begin
                            state_q    <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            mem_wr_req  <= 1'b1;
                            mem_wr_addr <= {acc_addr_c[ADDR_W-1:2], 2'b00};
                            mem_wr_data <= req_wdata;
                            resp_valid  <= 1'b1;
                            resp_rdata  <= '0;
                        end else begin
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= {acc_addr_c[ADDR_W-1:2], 2'b00};
                            state_q     <= req_we ? RMW_WAIT : RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (mem_data_valid) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data_c;
                        state_q    <= IDLE;
                    end else if (timeout_c) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                RMW_WAIT: begin
                    if (mem_data_valid) begin
                        mem_wr_req  <= 1'b1;
                        mem_wr_addr <= {cap_addr[ADDR_W-1:2], 2'b00};
                        mem_wr_data <= merge_data_c;
                        resp_valid  <= 1'b1;
                        resp_rdata  <= '0;
                        state_q     <= IDLE;
                    end else if (timeout_c) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ERR: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, corner sequences and random traffic vs. a word-memory model.
module tb_lsu_ctrl;

    localparam int unsigned AW  = 15;
    localparam int unsigned TMO = 15;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic          mem_data_valid;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;

    lsu_ctrl #(.ADDR_W(AW), .RD_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_rd_req     (mem_rd_req),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_data_valid (mem_data_valid),
        .mem_wr_req     (mem_wr_req),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem [0:8191];
    logic        pv [0:1];
    logic [31:0] pd [0:1];
    logic        block_dv = 1'b0;

    int          obs_rd, obs_wr, obs_resp;
    logic        obs_both;
    logic [AW-1:0] obs_ra, obs_wa;
    logic [31:0] obs_wd, obs_rdata;
    logic        obs_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic clear_obs();
        obs_rd = 0; obs_wr = 0; obs_resp = 0; obs_both = 1'b0;
        obs_ra = '0; obs_wa = '0; obs_wd = '0; obs_rdata = '0; obs_err = 1'b0;
    endtask

    // One cycle: advance the 2-cycle read pipe of the memory, apply writes, log DUT outputs.
    task automatic tick();
        @(negedge clk);
        mem_data_valid = pv[1];
        mem_rd_data    = pv[1] ? pd[1] : $urandom;
        pv[1] = pv[0];
        pd[1] = pd[0];
        pv[0] = mem_rd_req && !block_dv;
        pd[0] = mem[mem_rd_addr[AW-1:2]];
        if (mem_wr_req) mem[mem_wr_addr[AW-1:2]] = mem_wr_data;
        if (mem_rd_req) begin obs_rd++; obs_ra = mem_rd_addr; end
        if (mem_wr_req) begin obs_wr++; obs_wa = mem_wr_addr; obs_wd = mem_wr_data; end
        if (mem_rd_req && mem_wr_req) obs_both = 1'b1;
        if (resp_valid) begin obs_resp++; obs_rdata = resp_rdata; obs_err = resp_err; end
    endtask

    // Issue one request and follow it to its response; lat = cycles after acceptance, -1 if none.
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [AW-1:0] addr, input logic [31:0] wd, output int lat);
        int n;
        clear_obs();
        n = 0;
        while (!req_ready && n < 30) begin tick(); n++; end
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = $urandom;
        n = 1;
        while (obs_resp == 0 && n < 40) begin tick(); n++; end
        lat = (obs_resp != 0) ? n : -1;
    endtask

    // Reference behaviour written from the access rules on a flat word array.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [AW-1:0] addr, input logic [31:0] wdata,
                                  output logic e_err, output logic [31:0] e_rdata, output int e_lat,
                                  output int e_rd, output int e_wr, output logic [AW-1:0] e_wa,
                                  output logic [31:0] e_wd, output logic [AW-1:0] e_ra);
        int unsigned a, off, w, v, mask;
        bit mis, trap;
        e_err = 1'b0; e_rdata = '0; e_lat = 0; e_rd = 0; e_wr = 0; e_wa = '0; e_wd = '0; e_ra = '0;
        a = 32'(addr);
        mis  = (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        trap = (sz == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = trap || mis;
`else
        mis = 1'b0;
`endif
        if (trap) begin e_err = 1'b1; e_lat = 1; return; end
        if (sz == 2'd1) a = a - a % 2;
        if (sz == 2'd2) a = a - a % 4;
        off = a % 4;
        w   = mem[a / 4];
        if (!we) begin
            e_rd = 1; e_ra = AW'(a - off); e_lat = 4;
            if (sz == 2'd0) begin
                v = (w >> (8 * off)) % 256;
                if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                v = (w >> (8 * off)) % 65536;
                if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
            end else v = w;
            e_rdata = v;
        end else if (sz == 2'd2) begin
            e_wr = 1; e_lat = 1; e_wa = AW'(a); e_wd = wdata;
        end else begin
            mask = ((sz == 2'd0) ? 32'd255 : 32'd65535) << (8 * off);
            e_rd = 1; e_ra = AW'(a - off); e_wr = 1; e_wa = AW'(a - off); e_lat = 4;
            e_wd = (w & ~mask) | ((wdata << (8 * off)) & mask);
        end
    endfunction

    task automatic compare(input string tag, input logic e_err, input logic [31:0] e_rdata,
                           input int e_lat, input int e_rd, input int e_wr, input logic [AW-1:0] e_wa,
                           input logic [31:0] e_wd, input logic [AW-1:0] e_ra, input int lat);
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check({tag, "_err"}, 32'(obs_err), 32'(e_err));
        check({tag, "_rdata"}, obs_rdata, e_rdata);
        check({tag, "_rd_count"}, 32'(obs_rd), 32'(e_rd));
        check({tag, "_wr_count"}, 32'(obs_wr), 32'(e_wr));
        check({tag, "_rd_wr_overlap"}, 32'(obs_both), 32'd0);
        if (e_rd != 0) check({tag, "_rd_addr"}, 32'(obs_ra), 32'(e_ra));
        if (e_wr != 0) begin
            check({tag, "_wr_addr"}, 32'(obs_wa), 32'(e_wa));
            check({tag, "_wr_data"}, obs_wd, e_wd);
        end
    endtask

    typedef struct {
        logic          we;
        logic [1:0]    sz;
        logic          uns;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic          pre;
        logic [31:0]   pre_word;
        logic          e_err;
        logic [31:0]   e_rdata;
        int            e_lat;
        int            e_rd;
        int            e_wr;
        logic [AW-1:0] e_wa;
        logic [31:0]   e_wd;
        logic [AW-1:0] e_ra;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] sz, logic uns, logic [AW-1:0] addr,
                                logic [31:0] wd, logic pre, logic [31:0] pre_word, logic e_err,
                                logic [31:0] e_rdata, int e_lat, int e_rd, int e_wr,
                                logic [AW-1:0] e_wa, logic [31:0] e_wd, logic [AW-1:0] e_ra);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.pre = pre;
        v.pre_word = pre_word; v.e_err = e_err; v.e_rdata = e_rdata; v.e_lat = e_lat;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_wa = e_wa; v.e_wd = e_wd; v.e_ra = e_ra;
        return v;
    endfunction

    initial begin
        vec_t vecs [$];
        int lat;
        logic e_err; logic [31:0] e_rdata; int e_lat, e_rd, e_wr;
        logic [AW-1:0] e_wa, e_ra; logic [31:0] e_wd;
        logic we, uns; logic [1:0] sz; logic [AW-1:0] addr; logic [31:0] wd;

        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rd_data = '0; mem_data_valid = 1'b0;
        clear_obs();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
        check("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_wr_data", mem_wr_data, 32'd0);
        check("rst_mem_addrs", 32'({mem_rd_addr, mem_wr_addr}), 32'd0);

        //             we  sz     uns addr     wdata          pre pre_word       err rdata          lat rd wr wa       wd             ra
        vecs.push_back(mk(1, 2'd2, 0, 15'h010, 32'hDEADBEEF, 0, 32'h0,         0, 32'h0,         1, 0, 1, 15'h010, 32'hDEADBEEF, 15'h0));
        vecs.push_back(mk(0, 2'd2, 0, 15'h010, 32'h0,        0, 32'h0,         0, 32'hDEADBEEF,  4, 1, 0, 15'h0,   32'h0,        15'h010));
        vecs.push_back(mk(0, 2'd0, 0, 15'h000, 32'h0,        1, 32'h807060F0,  0, 32'hFFFFFFF0,  4, 1, 0, 15'h0,   32'h0,        15'h000));
        vecs.push_back(mk(0, 2'd0, 1, 15'h000, 32'h0,        0, 32'h0,         0, 32'h000000F0,  4, 1, 0, 15'h0,   32'h0,        15'h000));
        vecs.push_back(mk(0, 2'd1, 0, 15'h002, 32'h0,        0, 32'h0,         0, 32'hFFFF8070,  4, 1, 0, 15'h0,   32'h0,        15'h000));
        vecs.push_back(mk(1, 2'd0, 0, 15'h005, 32'h000000AA, 1, 32'h11223344,  0, 32'h0,         4, 1, 1, 15'h004, 32'h1122AA44, 15'h004));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 2'd1, 0, 15'h003, 32'h0,        1, 32'h807060F0,  1, 32'h0,         1, 0, 0, 15'h0,   32'h0,        15'h0));
        vecs.push_back(mk(1, 2'd2, 0, 15'h013, 32'h0BADF00D, 0, 32'h0,         1, 32'h0,         1, 0, 0, 15'h0,   32'h0,        15'h0));
`else
        vecs.push_back(mk(0, 2'd1, 0, 15'h003, 32'h0,        1, 32'h807060F0,  0, 32'hFFFF8070,  4, 1, 0, 15'h0,   32'h0,        15'h000));
        vecs.push_back(mk(1, 2'd2, 0, 15'h013, 32'h0BADF00D, 0, 32'h0,         0, 32'h0,         1, 0, 1, 15'h010, 32'h0BADF00D, 15'h0));
`endif
        vecs.push_back(mk(0, 2'd3, 0, 15'h008, 32'h0,        0, 32'h0,         1, 32'h0,         1, 0, 0, 15'h0,   32'h0,        15'h0));
        vecs.push_back(mk(1, 2'd1, 0, 15'h00A, 32'h1234BEEF, 1, 32'h11223344,  0, 32'h0,         4, 1, 1, 15'h008, 32'hBEEF3344, 15'h008));
        vecs.push_back(mk(0, 2'd0, 0, 15'h007, 32'h0,        1, 32'h7F000000,  0, 32'h0000007F,  4, 1, 0, 15'h0,   32'h0,        15'h004));
        vecs.push_back(mk(0, 2'd0, 0, 15'h006, 32'h0,        1, 32'h00800000,  0, 32'hFFFFFF80,  4, 1, 0, 15'h0,   32'h0,        15'h004));
        vecs.push_back(mk(1, 2'd3, 0, 15'h020, 32'h55555555, 0, 32'h0,         1, 32'h0,         1, 0, 0, 15'h0,   32'h0,        15'h0));

        foreach (vecs[i]) begin
            if (vecs[i].pre) mem[vecs[i].addr[AW-1:2]] = vecs[i].pre_word;
            run_txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, lat);
            compare($sformatf("vec%0d", i), vecs[i].e_err, vecs[i].e_rdata, vecs[i].e_lat,
                    vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_ra, lat);
        end

        // resp_rdata holds after a load response
        mem[15'h030 >> 2] = 32'hCAFEF00D;
        run_txn(1'b0, 2'd2, 1'b0, 15'h030, 32'h0, lat);
        check("hold_rdata_resp", obs_rdata, 32'hCAFEF00D);
        repeat (3) tick();
        check("hold_rdata_later", resp_rdata, 32'hCAFEF00D);

        // Read and RMW timeouts with memory silent
        block_dv = 1'b1;
        run_txn(1'b0, 2'd2, 1'b0, 15'h020, 32'h0, lat);
        compare("tmo_load", 1'b1, 32'h0, TMO + 1, 1, 0, '0, '0, 15'h020, lat);
        check("tmo_load_ready", 32'(req_ready), 32'd1);
        run_txn(1'b1, 2'd0, 1'b0, 15'h021, 32'h5A, lat);
        compare("tmo_rmw", 1'b1, 32'h0, TMO + 1, 1, 0, '0, '0, 15'h020, lat);
        block_dv = 1'b0;
        repeat (4) tick();

        // Back-to-back: load accepted in the store's response cycle
        run_txn(1'b1, 2'd2, 1'b0, 15'h040, 32'h13579BDF, lat);
        compare("b2b_store", 1'b0, 32'h0, 1, 0, 1, 15'h040, 32'h13579BDF, '0, lat);
        check("b2b_ready_in_resp", 32'(req_ready), 32'd1);
        run_txn(1'b0, 2'd1, 1'b1, 15'h042, 32'h0, lat);
        compare("b2b_load", 1'b0, 32'h00001357, 4, 1, 0, '0, '0, 15'h040, lat);

        // Reset while in RMW_WAIT; read data shows up after the block is idle
        clear_obs();
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 15'h051; req_wdata = 32'hEE;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rst_mid_rd_issued", 32'(obs_rd), 32'd1);
        reset = 1'b1;
        clear_obs();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("rst_mid_no_wr", 32'(obs_wr), 32'd0);
        check("rst_mid_no_resp", 32'(obs_resp), 32'd0);
        check("rst_mid_no_rd", 32'(obs_rd), 32'd0);
        check("rst_mid_idle", 32'(req_ready), 32'd1);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            we   = 1'($urandom);
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns  = 1'($urandom);
            addr = AW'($urandom_range(0, 127));
            wd   = $urandom;
            model(we, sz, uns, addr, wd, e_err, e_rdata, e_lat, e_rd, e_wr, e_wa, e_wd, e_ra);
            run_txn(we, sz, uns, addr, wd, lat);
            compare($sformatf("rnd%0d", t), e_err, e_rdata, e_lat, e_rd, e_wr, e_wa, e_wd, e_ra, lat);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the core's execute stage and the dual-SPRAM word memory.
- Memory accepts only full 32-bit word reads/writes at a word-aligned address.
- This block turns byte/half/word loads and stores into that form: read-modify-write for sub-word stores; lane extraction and sign/zero extension for loads.
- One access in flight; strict request/response handshake toward the core.

Parameters:
- ADDR_W, 15, byte-address width shared with memory.
- RD_TIMEOUT, 15, max cycles in a wait state before an access aborts with error; valid range 3..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core access request
- req_ready  out  1  block idle, request accepted when req_valid&&req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  misaligned/reserved size/timeout, valid with resp_valid
- mem_rd_req  out  1  one-cycle read strobe
- mem_rd_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- mem_rd_data  in  32  memory read word
- mem_data_valid  in  1  read data valid, 2 cycles after mem_rd_req
- mem_wr_req  out  1  one-cycle full-word write strobe
- mem_wr_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- mem_wr_data  out  32  full merged word

Behaviour:
- Reset (sync, active-high): state IDLE; timeout counter 0; captured request cleared. Outputs resp_valid, resp_err, mem_rd_req, mem_wr_req = 0; resp_rdata, mem addresses, mem_wr_data = 0.
- Reset mid-operation: any in-flight access is abandoned. mem_data_valid arriving afterwards is ignored while IDLE. No strobe is issued in the cycle after reset.
- req_ready = (state==IDLE). Request fields are captured on acceptance; later input changes are ignored.
- States: IDLE, RD_WAIT, RMW_WAIT, ERR.
- Every output strobe is registered and high for exactly one cycle.
- mem_rd_req and mem_wr_req are never high in the same cycle, because memory gives write address priority.
- Accept-time checks: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> ERR.
  - ERR: resp_valid=1, resp_err=1, no memory strobe.
  - Latency is 1 cycle after acceptance; state then returns to IDLE.
- Load: accept at cycle 0; mem_rd_req=1 at cycle 1; state RD_WAIT.
  - On mem_data_valid, byte lane k=addr[1:0] is bits [8k+7:8k]; half lane is addr[1]. Data is right-justified, then sign- or zero-extended.
  - resp_valid registered the next cycle (cycle 4 nominal).
- Word store: mem_wr_req=1 with resp_valid=1 at cycle 1; stays IDLE.
- Sub-word store (RMW): mem_rd_req at cycle 1; state RMW_WAIT.
  - On mem_data_valid, the addressed lanes are replaced with req_wdata[7:0] or [15:0].
  - mem_wr_req=1 with resp_valid=1 in the next cycle (cycle 4 nominal).
- Timeout: the counter increments each cycle in RD_WAIT/RMW_WAIT. On reaching RD_TIMEOUT: resp_valid=1, resp_err=1, no write issued, back to IDLE.
- req_ready is high in the resp_valid cycle, so a back-to-back accept is legal. A new request's strobe lands at least one cycle after the previous mem_wr_req.
- resp_rdata holds its value between responses.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: misalignment yields resp_err as above.
- Undefined: misaligned half/word addresses are aligned down (addr&~1 / addr&~3) and the access proceeds normally. Reserved size still errors.

Decomposition:
- Shared package lsu_pkg: size encodings (SZ_BYTE=2'b00, SZ_HALF, SZ_WORD), FSM state encoding, memory read latency constant MEM_RD_LAT=2.
- One sub-module, lsu_lane_unit: combinational extraction/extension for loads and lane merge for stores. The FSM stays in lsu_ctrl.

Test Plan:
- Word store 0xDEADBEEF @0x0010, then word load @0x0010 -> mem_wr_req cycle 1 with addr 0x0010; load resp_rdata=0xDEADBEEF at cycle 4, resp_err=0.
- Memory word 0x8070_60F0; byte load @0x0000 signed -> 0xFFFFFFF0; unsigned -> 0x000000F0; signed half @0x0002 -> 0xFFFF8070.
- Byte store 0xAA @0x0005 over memory 0x11223344 -> one mem_rd_req, then mem_wr_data=0x1122AA44 @0x0004 with resp_valid in the same cycle.
- Half load @0x0003 -> with macro: resp_err=1 at cycle 1, no mem strobes; without macro: reads @0x0000, returns half lane 1.
- mem_data_valid held low -> resp_err=1 after 15 wait cycles, no mem_wr_req; then req_ready=1.
- Reset asserted in RMW_WAIT, mem_data_valid arrives 1 cycle later -> no mem_wr_req, no resp_valid; state IDLE.
